// File: rtl/vblank_update_arbiter.sv
// Round-robin arbiter that hands the game-state update resource to one requester at a time, only inside vertical blanking.
// Optional grant watchdog is enabled by defining VBA_WATCHDOG_EN.
//
// state | meaning
// IDLE  | outside a blanking window, waiting for vblnk to rise
// ARB   | window open, looking for an eligible requester
// GRANT | one requester owns the update resource until done
module vblank_update_arbiter #(
  parameter int N_REQ            = 4,
  parameter int MAX_GRANT_CYCLES = 4096,
  parameter int FRAME_CNT_W      = 16
) (
  input  logic                   clk60MHz,
  input  logic                   rst,
  input  logic                   vblnk,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       grant,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int IDXW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_GRANT_CYCLES < 1) begin : g_param_check
    $error("vblank_update_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t           state;
  logic             vblnk_q;
  logic [N_REQ-1:0] served;
  logic [IDXW-1:0]  rr;
  logic [IDXW-1:0]  gidx;

  logic             wo;
  logic             gdone;
  logic             found;
  logic [IDXW-1:0]  pick;
  logic [N_REQ-1:0] eligible;
  logic             wd_expire;

  assign wo    = vblnk & ~vblnk_q;
  assign gdone = done[gidx];
  // The served mask is being cleared this very cycle when a window opens.
  assign eligible = req & ~(wo ? '0 : served);

`ifdef VBA_WATCHDOG_EN
  localparam int WDW = $clog2(MAX_GRANT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;
  assign wd_expire = (wd_cnt == WDW'(MAX_GRANT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // Walk downward so the lowest offset from rr is the one left in pick.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (eligible[(int'(rr) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = IDXW'((int'(rr) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state       <= IDLE;
      vblnk_q     <= 1'b0;
      served      <= '0;
      rr          <= '0;
      gidx        <= '0;
      grant       <= '0;
      frame_tick  <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef VBA_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      vblnk_q     <= vblnk;
      frame_tick  <= wo;
      timeout_err <= 1'b0;
      if (wo) frame_cnt <= frame_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (wo) state <= ARB;
        end
        ARB: begin
          if (!vblnk) begin
            state <= IDLE;
          end else if (found) begin
            grant <= N_REQ'(1) << pick;
            gidx  <= pick;
            rr    <= (pick == IDXW'(N_REQ - 1)) ? '0 : pick + 1'b1;
            state <= GRANT;
`ifdef VBA_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (gdone) begin
            grant        <= '0;
            served[gidx] <= 1'b1;
            state        <= ARB;
          end else begin
            if (!vblnk && vblnk_q) overrun <= 1'b1;
            if (wd_expire) begin
              grant        <= '0;
              served[gidx] <= 1'b1;
              timeout_err  <= 1'b1;
              state        <= ARB;
            end
`ifdef VBA_WATCHDOG_EN
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // A new window wins over a release marking served in the same cycle.
      if (wo) begin
        served  <= '0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
